// File: rtl/vga_pkg.sv
// Shared raster constants for the 640x480@60 Pong display path, also used by renderers for playfield bounds.
// Latency: n/a (constants, types and a pure helper function).
// Backpressure: n/a.
package vga_pkg;

  localparam int COUNT_W = 10;

  // Default 640x480@60 timing, in pixels and lines
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_CLK_DIV   = 2;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Inclusive sync windows for the default timing
  localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

  typedef logic [COUNT_W-1:0] count_t;

  // True when c lies in the inclusive range [lo, hi]
  function automatic logic in_window(input count_t c, input count_t lo, input count_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster bus between the timing generator and the pixel renderers / VGA connector.
// Latency: n/a (wiring only).
// Backpressure: none; master free-runs and slaves follow pix_en.
interface vga_timing_if;
  import vga_pkg::*;

  logic   r_in;
  logic   g_in;
  logic   b_in;
  count_t hcount;
  count_t vcount;
  logic   pix_en;
  logic   visible;
  logic   frame_tick;
  logic   hsync;
  logic   vsync;
  logic   r;
  logic   g;
  logic   b;

  modport master (
    input  r_in, g_in, b_in,
    output hcount, vcount, pix_en, visible, frame_tick, hsync, vsync, r, g, b
  );

  modport slave (
    output r_in, g_in, b_in,
    input  hcount, vcount, pix_en, visible, frame_tick, hsync, vsync, r, g, b
  );

endinterface

// File: rtl/vga_timing_pix_clk_en.sv
// Pixel-rate divider: one-clk pix_en strobe every CLK_DIV system clocks (CLK_DIV must be 2 or more).
// Latency: first strobe is high in the cycle closed by the CLK_DIV-th rising edge after reset release.
// Backpressure: none; free-running.
module pix_clk_en #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic pix_en
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;

  // Count 0..CLK_DIV-1 and wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (div_q == DIV_MAX) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Decoded straight from the register, so it is low throughout reset
  assign pix_en = (div_q == DIV_MAX);

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: h/v counters, sync decode and blanked, sync-aligned pixel output register.
// Latency: counters step on pix_en; r/g/b/hsync/vsync appear one clk after the pix_en that sampled them.
// Backpressure: none; free-running raster, renderers must have r_in/g_in/b_in valid by the next pix_en.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input logic          clk,
  input logic          reset_n,
  vga_timing_if.master vga
);

  // Totals must stay below 1024 so the 10-bit counters never alias
  localparam count_t H_LAST  = COUNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam count_t V_LAST  = COUNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam count_t H_VIS   = COUNT_W'(H_VISIBLE);
  localparam count_t V_VIS   = COUNT_W'(V_VISIBLE);
  localparam count_t HS_LO   = COUNT_W'(H_VISIBLE + H_FP);
  localparam count_t HS_HI   = COUNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam count_t VS_LO   = COUNT_W'(V_VISIBLE + V_FP);
  localparam count_t VS_HI   = COUNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic   pix_en;
  count_t hcount_q;
  count_t vcount_q;
  logic   visible;
  logic   hsync_d;
  logic   vsync_d;
  logic   frame_tick;
  logic   r_q, g_q, b_q;
  logic   hsync_q, vsync_q;

  pix_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_clk_en (
    .clk     (clk),
    .reset_n (reset_n),
    .pix_en  (pix_en)
  );

  // Raster position: column steps every pixel, line steps when the column wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else if (pix_en) begin
      if (hcount_q == H_LAST) begin
        hcount_q <= '0;
        if (vcount_q == V_LAST) begin
          vcount_q <= '0;
        end else begin
          vcount_q <= vcount_q + COUNT_W'(1);
        end
      end else begin
        hcount_q <= hcount_q + COUNT_W'(1);
      end
    end
  end

  // Visibility, active-low sync decode and start-of-vblank tick for the current position
  always_comb begin
    visible    = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    hsync_d    = ~in_window(hcount_q, HS_LO, HS_HI);
    vsync_d    = ~in_window(vcount_q, VS_LO, VS_HI);
    frame_tick = pix_en && (hcount_q == '0) && (vcount_q == V_VIS);
  end

  // Colour and sync are captured on the same pix_en so they always describe one pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q     <= 1'b0;
      g_q     <= 1'b0;
      b_q     <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (pix_en) begin
      r_q     <= vga.r_in & visible;
      g_q     <= vga.g_in & visible;
      b_q     <= vga.b_in & visible;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign vga.hcount     = hcount_q;
  assign vga.vcount     = vcount_q;
  assign vga.pix_en     = pix_en;
  assign vga.visible    = visible;
  assign vga.frame_tick = frame_tick;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.r          = r_q;
  assign vga.g          = g_q;
  assign vga.b          = b_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default-timing instance for line-level checks, shrunken instance for frame-level checks.
// Latency: expected pixels are queued on each pix_en and compared the following clk.
// Backpressure: n/a.
module tb_vga_timing;
  import vga_pkg::*;

  // Shrunken raster so whole frames fit in a short run; CLK_DIV=3 exercises a non-default divider
  localparam int S_HV = 16, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VV = 10, S_VF = 2, S_VS = 2, S_VB = 2;
  localparam int S_DIV = 3;
  localparam int S_HT = 24, S_VT = 16;
  localparam int S_HS0 = 18, S_HS1 = 20, S_VS0 = 12, S_VS1 = 13;
  localparam int S_FRAME_CLKS = S_HT * S_VT * S_DIV;        // 1152
  localparam int S_TICK_K = (S_VV * S_HT) * S_DIV + S_DIV - 1; // 722
  localparam int D_DIV = 2;

  typedef struct {
    logic [4:0] px;   // {r,g,b,hsync,vsync}
    int         h;
    int         v;
    int         f;
  } sb_t;

  logic clk = 1'b0;
  logic rst_d_n;
  logic rst_s_n;
  int   checks = 0;
  int   failures = 0;
  sb_t  sb_q[$];
  sb_t  cur;

  always #5 clk = ~clk;

  vga_timing_if d_if();
  vga_timing_if s_if();

  vga_timing u_dut_d (
    .clk     (clk),
    .reset_n (rst_d_n),
    .vga     (d_if)
  );

  vga_timing #(
    .H_VISIBLE (S_HV), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
    .V_VISIBLE (S_VV), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
    .CLK_DIV   (S_DIV)
  ) u_dut_s (
    .clk     (clk),
    .reset_n (rst_s_n),
    .vga     (s_if)
  );

  // Expected registered output for a pixel sampled at (h,v) with the given renderer bits
  function automatic logic [4:0] exp_px(input int h, input int v, input logic ri, input logic gi,
                                         input logic bi, input int hv, input int vv, input int hs0,
                                         input int hs1, input int vs0, input int vs1);
    logic vis;
    vis = (h < hv) && (v < vv);
    return {ri & vis, gi & vis, bi & vis, !(h >= hs0 && h <= hs1), !(v >= vs0 && v <= vs1)};
  endfunction

  task automatic test_reset();
    rst_d_n = 1'b0;
    rst_s_n = 1'b0;
    d_if.r_in = 1'b1; d_if.g_in = 1'b1; d_if.b_in = 1'b1;
    s_if.r_in = 1'b1; s_if.g_in = 1'b1; s_if.b_in = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({d_if.hcount, d_if.vcount, d_if.pix_en, d_if.frame_tick} !== 22'd0) begin
      failures++;
      $display("FAIL reset_d_count got h=%0d v=%0d pe=%b ft=%b need 0/0/0/0",
               d_if.hcount, d_if.vcount, d_if.pix_en, d_if.frame_tick);
    end
    checks++;
    if ({d_if.r, d_if.g, d_if.b, d_if.hsync, d_if.vsync} !== 5'b00011) begin
      failures++;
      $display("FAIL reset_d_out got %b need 00011", {d_if.r, d_if.g, d_if.b, d_if.hsync, d_if.vsync});
    end
    checks++;
    if ({s_if.hcount, s_if.vcount, s_if.pix_en, s_if.frame_tick} !== 22'd0) begin
      failures++;
      $display("FAIL reset_s_count got h=%0d v=%0d pe=%b ft=%b need 0/0/0/0",
               s_if.hcount, s_if.vcount, s_if.pix_en, s_if.frame_tick);
    end
    checks++;
    if ({s_if.r, s_if.g, s_if.b, s_if.hsync, s_if.vsync, s_if.visible} !== 6'b000111) begin
      failures++;
      $display("FAIL reset_s_out got %b need 000111",
               {s_if.r, s_if.g, s_if.b, s_if.hsync, s_if.vsync, s_if.visible});
    end
  endtask

  // Default timing: divider phase, first line, hsync window and blanking at column 640
  task automatic test_default_line();
    int  first_pe, wrap_k, hs_low, hs_first, hs_last, r_line0, prev_h;
    sb_t e;
    first_pe = -1; wrap_k = -1; hs_low = 0; hs_first = -1; hs_last = -1; r_line0 = 0; prev_h = 0;
    sb_q.delete();
    cur.px = 5'b00011; cur.h = -1; cur.v = -1; cur.f = 0;
    @(negedge clk);
    rst_d_n = 1'b1;
    for (int k = 0; k <= 1700; k++) begin
      int   n, h, v;
      logic pe;
      n = k / D_DIV; h = n % H_TOTAL; v = n / H_TOTAL; pe = (k % D_DIV) == D_DIV - 1;
      checks++;
      if ({d_if.hcount, d_if.vcount, d_if.pix_en} !== {10'(h), 10'(v), pe}) begin
        failures++;
        $display("FAIL d_count k=%0d got h=%0d v=%0d pe=%b need h=%0d v=%0d pe=%b",
                 k, d_if.hcount, d_if.vcount, d_if.pix_en, h, v, pe);
      end
      if (d_if.pix_en === 1'b1 && first_pe < 0) first_pe = k;
      if (k > 0 && d_if.hcount == 0 && prev_h == H_TOTAL - 1 && wrap_k < 0) wrap_k = k;
      prev_h = int'(d_if.hcount);
      if (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        if (cur.v == 0) begin
          if (d_if.hsync === 1'b0) begin
            hs_low++;
            if (hs_first < 0) hs_first = cur.h;
            hs_last = cur.h;
          end
          if (d_if.r === 1'b1) r_line0++;
        end
      end
      checks++;
      if ({d_if.r, d_if.g, d_if.b, d_if.hsync, d_if.vsync} !== cur.px) begin
        failures++;
        $display("FAIL d_pixel k=%0d px=(%0d,%0d) got %b need %b", k, cur.h, cur.v,
                 {d_if.r, d_if.g, d_if.b, d_if.hsync, d_if.vsync}, cur.px);
      end
      if (pe) begin
        e.px = exp_px(h, v, 1'b1, 1'b1, 1'b1, DEF_H_VISIBLE, DEF_V_VISIBLE,
                      H_SYNC_START, H_SYNC_END, V_SYNC_START, V_SYNC_END);
        e.h = h; e.v = v; e.f = 0;
        sb_q.push_back(e);
      end
      @(negedge clk);
    end
    // k=1 is the cycle closed by the 2nd rising edge
    checks++;
    if (first_pe != 1) begin
      failures++;
      $display("FAIL d_first_pix_en got k=%0d need k=1", first_pe);
    end
    checks++;
    if (wrap_k != 2 * H_TOTAL) begin
      failures++;
      $display("FAIL d_line_wrap got %0d clks need %0d", wrap_k, 2 * H_TOTAL);
    end
    checks++;
    if (hs_low != DEF_H_SYNC || hs_first != 656 || hs_last != 751) begin
      failures++;
      $display("FAIL d_hsync_window got n=%0d %0d..%0d need n=96 656..751", hs_low, hs_first, hs_last);
    end
    checks++;
    if (r_line0 != DEF_H_VISIBLE) begin
      failures++;
      $display("FAIL d_blank_line0 got %0d lit pixels need %0d", r_line0, DEF_H_VISIBLE);
    end
  endtask

  // Two full small frames with all renderer bits high: counters, ticks, vsync window, blanking
  task automatic test_frame_small();
    int  vs_low, vs_first, vs_last, hs_low;
    int  tick_q[$];
    sb_t e;
    vs_low = 0; vs_first = -1; vs_last = -1; hs_low = 0;
    sb_q.delete();
    cur.px = 5'b00011; cur.h = -1; cur.v = -1; cur.f = 0;
    s_if.r_in = 1'b1; s_if.g_in = 1'b1; s_if.b_in = 1'b1;
    @(negedge clk); rst_s_n = 1'b0;
    @(negedge clk); rst_s_n = 1'b1;
    for (int k = 0; k <= 2 * S_FRAME_CLKS + 100; k++) begin
      int   n, h, v;
      logic pe, ft, vis;
      n = k / S_DIV; h = n % S_HT; v = (n / S_HT) % S_VT;
      pe = (k % S_DIV) == S_DIV - 1;
      ft = pe && h == 0 && v == S_VV;
      vis = (h < S_HV) && (v < S_VV);
      checks++;
      if ({s_if.hcount, s_if.vcount, s_if.pix_en, s_if.frame_tick, s_if.visible} !==
          {10'(h), 10'(v), pe, ft, vis}) begin
        failures++;
        $display("FAIL s_count k=%0d got h=%0d v=%0d pe=%b ft=%b vis=%b need h=%0d v=%0d pe=%b ft=%b vis=%b",
                 k, s_if.hcount, s_if.vcount, s_if.pix_en, s_if.frame_tick, s_if.visible, h, v, pe, ft, vis);
      end
      if (s_if.frame_tick === 1'b1) tick_q.push_back(k);
      if (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        if (cur.f == 0 && s_if.vsync === 1'b0) begin
          vs_low++;
          if (vs_first < 0) vs_first = cur.v;
          vs_last = cur.v;
        end
        if (cur.f == 0 && cur.v == 0 && s_if.hsync === 1'b0) hs_low++;
      end
      checks++;
      if ({s_if.r, s_if.g, s_if.b, s_if.hsync, s_if.vsync} !== cur.px) begin
        failures++;
        $display("FAIL s_pixel k=%0d px=(%0d,%0d) got %b need %b", k, cur.h, cur.v,
                 {s_if.r, s_if.g, s_if.b, s_if.hsync, s_if.vsync}, cur.px);
      end
      if (pe) begin
        e.px = exp_px(h, v, 1'b1, 1'b1, 1'b1, S_HV, S_VV, S_HS0, S_HS1, S_VS0, S_VS1);
        e.h = h; e.v = v; e.f = n / (S_HT * S_VT);
        sb_q.push_back(e);
      end
      @(negedge clk);
    end
    checks++;
    if (vs_low != S_VS * S_HT || vs_first != S_VS0 || vs_last != S_VS1) begin
      failures++;
      $display("FAIL s_vsync_window got n=%0d lines %0d..%0d need n=%0d lines %0d..%0d",
               vs_low, vs_first, vs_last, S_VS * S_HT, S_VS0, S_VS1);
    end
    checks++;
    if (hs_low != S_HS) begin
      failures++;
      $display("FAIL s_hsync_width got %0d need %0d", hs_low, S_HS);
    end
    checks++;
    if (tick_q.size() != 2) begin
      failures++;
      $display("FAIL s_tick_count got %0d need 2", tick_q.size());
    end else begin
      checks++;
      if (tick_q[0] != S_TICK_K || tick_q[1] - tick_q[0] != S_FRAME_CLKS) begin
        failures++;
        $display("FAIL s_tick_timing got first=%0d period=%0d need first=%0d period=%0d",
                 tick_q[0], tick_q[1] - tick_q[0], S_TICK_K, S_FRAME_CLKS);
      end
    end
  endtask

  // Single lit pixel at (8,5): exactly one registered r pixel per frame, aligned with its sync
  task automatic test_pixel_alignment();
    int  r_pops, r_at_target, r_cycles;
    sb_t e;
    r_pops = 0; r_at_target = 0; r_cycles = 0;
    sb_q.delete();
    cur.px = 5'b00011; cur.h = -1; cur.v = -1; cur.f = 0;
    s_if.r_in = 1'b0; s_if.g_in = 1'b0; s_if.b_in = 1'b0;
    @(negedge clk); rst_s_n = 1'b0;
    @(negedge clk); rst_s_n = 1'b1;
    for (int k = 0; k <= 2 * S_FRAME_CLKS + 100; k++) begin
      int n, h, v;
      n = k / S_DIV; h = n % S_HT; v = (n / S_HT) % S_VT;
      s_if.r_in = (h == 8 && v == 5);
      if (s_if.r === 1'b1) r_cycles++;
      if (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        if (s_if.r === 1'b1) begin
          r_pops++;
          if (cur.h == 8 && cur.v == 5) r_at_target++;
        end
      end
      checks++;
      if ({s_if.r, s_if.g, s_if.b, s_if.hsync, s_if.vsync} !== cur.px) begin
        failures++;
        $display("FAIL align_pixel k=%0d px=(%0d,%0d) got %b need %b", k, cur.h, cur.v,
                 {s_if.r, s_if.g, s_if.b, s_if.hsync, s_if.vsync}, cur.px);
      end
      if ((k % S_DIV) == S_DIV - 1) begin
        e.px = exp_px(h, v, s_if.r_in, 1'b0, 1'b0, S_HV, S_VV, S_HS0, S_HS1, S_VS0, S_VS1);
        e.h = h; e.v = v; e.f = 0;
        sb_q.push_back(e);
      end
      @(negedge clk);
    end
    checks++;
    if (r_pops != 2 || r_at_target != 2) begin
      failures++;
      $display("FAIL align_count got %0d lit pixels (%0d at target) need 2 (2)", r_pops, r_at_target);
    end
    checks++;
    if (r_cycles != 2 * S_DIV) begin
      failures++;
      $display("FAIL align_hold got %0d lit clks need %0d", r_cycles, 2 * S_DIV);
    end
    s_if.r_in = 1'b0;
  endtask

  // Reset mid-line at (12,7): immediate asynchronous clear, restart from (0,0), tick only at (0,V_VISIBLE)
  task automatic test_midframe_reset();
    int first_tick;
    first_tick = -1;
    s_if.r_in = 1'b1; s_if.g_in = 1'b1; s_if.b_in = 1'b1;
    @(negedge clk); rst_s_n = 1'b0;
    @(negedge clk); rst_s_n = 1'b1;
    repeat ((7 * S_HT + 12) * S_DIV + 1) @(negedge clk);
    checks++;
    if ({s_if.hcount, s_if.vcount, s_if.r} !== {10'd12, 10'd7, 1'b1}) begin
      failures++;
      $display("FAIL mid_position got h=%0d v=%0d r=%b need h=12 v=7 r=1", s_if.hcount, s_if.vcount, s_if.r);
    end
    #2 rst_s_n = 1'b0;
    #1;
    checks++;
    if ({s_if.hcount, s_if.vcount, s_if.pix_en, s_if.frame_tick, s_if.r, s_if.g, s_if.b,
         s_if.hsync, s_if.vsync} !== {22'd0, 5'b00011}) begin
      failures++;
      $display("FAIL mid_async_clear got h=%0d v=%0d pe=%b ft=%b out=%b need 0/0/0/0 out=00011",
               s_if.hcount, s_if.vcount, s_if.pix_en, s_if.frame_tick,
               {s_if.r, s_if.g, s_if.b, s_if.hsync, s_if.vsync});
    end
    @(negedge clk); rst_s_n = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      int n, h, v;
      n = k / S_DIV; h = n % S_HT; v = (n / S_HT) % S_VT;
      checks++;
      if ({s_if.hcount, s_if.vcount} !== {10'(h), 10'(v)}) begin
        failures++;
        $display("FAIL mid_restart k=%0d got h=%0d v=%0d need h=%0d v=%0d", k, s_if.hcount, s_if.vcount, h, v);
      end
      if (s_if.frame_tick === 1'b1 && first_tick < 0) first_tick = k;
      @(negedge clk);
    end
    checks++;
    if (first_tick != S_TICK_K) begin
      failures++;
      $display("FAIL mid_first_tick got k=%0d need k=%0d", first_tick, S_TICK_K);
    end
  endtask

  initial begin
    test_reset();
    test_default_line();
    test_frame_small();
    test_pixel_alignment();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the Pong display path, running 640x480 at 60 Hz. It produces the hcount/vcount stream consumed by the ball, paddle and score renderers. It also collects their composited pixel bits and drives the final blanked, sync-aligned r/g/b/hsync/vsync to the VGA connector. A once-per-frame tick tells game logic when it may safely move objects during vertical blank.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel; legal values are 2 or more

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous, active-low reset
- r_in, g_in, b_in  in  1 each  composited pixel from renderers, valid for current hcount/vcount
- hcount  out  10  current pixel column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- pix_en  out  1  one-clk strobe, once every CLK_DIV clocks; the pixel-advance qualifier
- visible  out  1  high when hcount < H_VISIBLE and vcount < V_VISIBLE (combinational from counters)
- frame_tick  out  1  one-clk pulse at start of vertical blank
- hsync, vsync  out  1 each  registered sync outputs, active-low
- r, g, b  out  1 each  registered, blanked pixel outputs

## Operation
- H_TOTAL is the sum of H_VISIBLE, H_FP, H_SYNC and H_BP, giving 800. V_TOTAL is the sum of the vertical terms, giving 525. Both counters are 10 bits; no parameter set may exceed 1023.
- Divider: counts 0..CLK_DIV-1 and asserts pix_en when it equals CLK_DIV-1, then wraps to 0.
- On pix_en:
  - If hcount is H_TOTAL-1, hcount goes to 0. Otherwise hcount increments.
  - When hcount wraps: if vcount is V_TOTAL-1, vcount goes to 0. Otherwise vcount increments.
  - Counters never change without pix_en.
- Sync windows:
  - hsync is low when hcount is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], which is 656..751.
  - vsync is low when vcount is in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], which is 490..491.
- Output register: in a pix_en cycle, the block samples the current counters and r_in/g_in/b_in, then registers:
  - r, g, b = the corresponding input AND visible
  - hsync and vsync = their decode for the same (hcount, vcount)
  - Sync and color therefore always describe the same pixel.
- frame_tick: high for exactly the one clk where pix_en is high and the counters read (0, V_VISIBLE). It fires once per frame.

## Timing
- Reset values, held while reset_n is low, apply asynchronously:
  - hcount=0, vcount=0, divider=0
  - pix_en=0, frame_tick=0
  - r=g=b=0, hsync=1, vsync=1
- After release: the first pix_en comes on the CLK_DIV-th rising clk edge. Counters first read (1,0) one clk after that.
- Renderer contract: hcount/vcount are stable for CLK_DIV clks. Renderers may register r_in/g_in/b_in one clk after a counter change; that result must be valid by the next pix_en.
- Output latency: one clk after the pix_en in which the pixel was sampled. The output then holds for CLK_DIV clks.
- Period: one line is 800×CLK_DIV clks and one frame is 420000×CLK_DIV clks.
- Wrap cases:
  - (799,524) advances to (0,0) in a single pix_en.
  - (799,479) advances to (0,480), and that cycle's pix_en also raises frame_tick.
- A reset asserted mid-line aborts the frame. The first frame after reset restarts at (0,0).

## Structure
- Shared package vga_pkg holds:
  - the default timing constants
  - derived H_TOTAL, V_TOTAL and the sync start/end values
  - a COUNT_W=10 constant
  - these are shared with the ball/paddle renderers for the playfield bounds
- One sub-module: pix_clk_en, the CLK_DIV divider producing pix_en.
- Counters, sync decode and the output register stay in vga_timing.

## Test plan
- Reset then free-run: assert reset_n=0, release, count clks. Expect the first pix_en at clk 2 and the hcount 799→0 wrap after 1600 clks. Expect 840000 clks between consecutive frame_ticks.
- Sync windows: hsync low for exactly 96 pix_en (hcount 656..751, seen one clk late on the output); vsync low for exactly 2 lines (vcount 490..491); both polarities active-low.
- Blanking: hold r_in=g_in=b_in=1. Output r/g/b=1 only for hcount<640 and vcount<480, and 0 elsewhere, including hcount=640 and vcount=480.
- Pixel alignment: drive r_in=1 only at (320,240). Expect exactly one registered r=1 pixel per frame, appearing one clk after the pix_en with counters at (320,240), coincident with hsync=1 and vsync=1.
- Mid-frame reset: pull reset_n low at (500,300). Outputs clear immediately and asynchronously; after release the counters restart at (0,0) and no frame_tick appears until (0,480).
